// File: rtl/bram_out_fifo_if.sv
// Handshake bundle between the BRAM read side, the beat FIFO and the 32-bit sink.
interface bram_out_fifo_if;
   logic [63:0] din;
   logic        din_valid;
   logic        din_ready;
   logic [31:0] dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        dout_last;

   // Driver side: produces words, consumes beats
   modport master (
      output din, din_valid, dout_ready,
      input  din_ready, dout, dout_valid, dout_last
   );

   // FIFO side: consumes words, produces beats
   modport slave (
      input  din, din_valid, dout_ready,
      output din_ready, dout, dout_valid, dout_last
   );
endinterface

// File: rtl/bram_out_fifo.sv
// Buffers 64-bit BRAM words and emits each one as two 32-bit beats.
// Optional beat counter enabled by defining BRAM_OUT_FIFO_CNT_EN.
module bram_out_fifo #(
   parameter int unsigned DEPTH    = 2,
   parameter bit          HI_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   bram_out_fifo_if.slave  bus,
   output logic [15:0]     beat_cnt
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_FIRST  = 2'd1,
      ST_SECOND = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic               din_ready_q, din_ready_d;
   logic               dout_valid_q, dout_valid_d;
   logic               dout_last_q, dout_last_d;
   logic [31:0]        dout_q, dout_d;
   logic [63:0]        mem_q [DEPTH];
   logic               push_c, pop_c, xfer_c;
   logic [63:0]        head_c;

   // Next-state, pointer/occupancy update and registered output computation
   always_comb begin
      state_d      = state_q;
      occ_d        = occ_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      xfer_c       = (state_q != ST_EMPTY) && bus.dout_ready && !clr;
      push_c       = bus.din_valid && din_ready_q && !clr;
      pop_c        = xfer_c && (state_q == ST_SECOND);
      head_c       = 64'h0;
      dout_d       = 32'h0;

      if (clr) begin
         state_d  = ST_EMPTY;
         occ_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push_c && !pop_c)      occ_d = occ_q + OCC_W'(1);
         else if (!push_c && pop_c) occ_d = occ_q - OCC_W'(1);

         case (state_q)
            ST_EMPTY:  if (occ_d != '0) state_d = ST_FIRST;
            ST_FIRST:  if (xfer_c) state_d = ST_SECOND;
            ST_SECOND: if (xfer_c) state_d = (occ_d != '0) ? ST_FIRST : ST_EMPTY;
            default:   state_d = ST_EMPTY;
         endcase
      end

      // Head entry as it will read after this edge; bypass a word landing in the head slot
      head_c = (push_c && (wr_ptr_q == rd_ptr_d)) ? bus.din : mem_q[rd_ptr_d];

      case (state_d)
         ST_FIRST:  dout_d = HI_FIRST ? head_c[63:32] : head_c[31:0];
         ST_SECOND: dout_d = HI_FIRST ? head_c[31:0]  : head_c[63:32];
         default:   dout_d = 32'h0;
      endcase
      din_ready_d  = (occ_d < DEPTH_OCC);
      dout_valid_d = (state_d != ST_EMPTY);
      dout_last_d  = (state_d == ST_SECOND);
   end

   // Control state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         occ_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         din_ready_q  <= 1'b1;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         dout_q       <= 32'h0;
      end else begin
         state_q      <= state_d;
         occ_q        <= occ_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         din_ready_q  <= din_ready_d;
         dout_valid_q <= dout_valid_d;
         dout_last_q  <= dout_last_d;
         dout_q       <= dout_d;
      end
   end

   // Word storage, deliberately left without reset
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= bus.din;
   end

   assign bus.din_ready  = din_ready_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.dout_last  = dout_last_q;
   assign bus.dout       = dout_q;

`ifdef BRAM_OUT_FIFO_CNT_EN
   logic [15:0] beat_cnt_q, beat_cnt_d;

   // Free-running beat counter, wraps naturally at 16 bits
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (clr)         beat_cnt_d = 16'h0;
      else if (xfer_c) beat_cnt_d = beat_cnt_q + 16'd1;
   end

   // Beat counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) beat_cnt_q <= 16'h0;
      else        beat_cnt_q <= beat_cnt_d;
   end

   assign beat_cnt = beat_cnt_q;
`else
   assign beat_cnt = 16'h0;
`endif

endmodule
